// File: rtl/fifo_uart_rx.sv
// fifo_uart_rx: 16x-oversampled 8N1 UART receiver feeding an RX FIFO with sticky error flags.
module fifo_uart_rx #(
  parameter int FIFO_DEPTH = 10
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            uart_clk_i,
  input  logic                            rx_en_i,
  input  logic                            rx_i,
  input  logic                            rden_i,
  input  logic                            clr_err_i,
  output logic [7:0]                      rd_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count_o,
  output logic [4:0]                      fifo_uart_rx_stat
);
  localparam int DATA_WIDTH = 8;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d, frm_q, frm_d;
  logic line, full, empty, push, pop, ovr_set, frm_set;
  assign line = sync_q[1];
  assign full = cnt_q == DEPTH;
  assign empty = cnt_q == '0;
  assign pop = rden_i && !empty;
  always_comb begin
    state_d = state_q;
    tick_d = uart_clk_i ? tick_q + 4'd1 : tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    push = 1'b0;
    ovr_set = 1'b0;
    frm_set = 1'b0;
    if (!rx_en_i) state_d = IDLE;
    else if (uart_clk_i)
      unique case (state_q)
        IDLE: if (!line) begin
          state_d = START;
          tick_d = '0;
        end
        START: if (tick_q == 4'd7) begin
          state_d = line ? IDLE : DATA;
          tick_d = '0;
          bit_d = '0;
        end
        DATA: if (tick_q == 4'd15) begin
          shift_d = {line, shift_q[DATA_WIDTH-1:1]};
          bit_d = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? STOP : DATA;
        end
        STOP: if (tick_q == 4'd15) begin
          state_d = IDLE;
          push = line && !full;
          ovr_set = line && full;
          frm_set = !line;
        end
        default: state_d = IDLE;
      endcase
  end
  // Push eligibility is judged on the registered count, so a same-cycle pop never frees space for it.
  always_comb begin
    wp_d = push ? (wp_q == LAST ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? (rp_q == LAST ? '0 : rp_q + 1'b1) : rp_q;
    rd_d = pop ? mem_q[rp_q] : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ovr_d = ovr_set || (ovr_q && !clr_err_i);
    frm_d = frm_set || (frm_q && !clr_err_i);
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      ovr_q <= ovr_d;
      frm_q <= frm_d;
    end
  always_ff @(posedge clk_i)
    if (push) mem_q[wp_q] <= shift_q;
  assign rd_data_o = rd_q;
  assign rx_count_o = cnt_q;
  assign fifo_uart_rx_stat = {full, empty, ovr_q, frm_q, state_q != IDLE};
endmodule
